// File: rtl/an_code_pkg.sv
// Shared constants and constant functions for the AN-code Barrett decoder.
package an_code_pkg;

    localparam int AN_A_DEF    = 37;
    localparam int AN_CW_W_DEF = 18;
    localparam int AN_D_W_DEF  = 13;

    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned t;
        r = 0;
        t = 1;
        while (t < v) begin
            t = t << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Barrett multiplier floor(2^k / a); k stays below 64.
    function automatic longint unsigned barrett_m(input longint unsigned a, input int k);
        return (longint'(1) << k) / a;
    endfunction

    // Bit offset of lane `lane` in a flat bus of `w`-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/an_barrett_lane.sv
// One lane of the AN decoder: input register, Barrett quotient, residue, correction.
module an_barrett_lane
    import an_code_pkg::*;
#(
    parameter int A    = AN_A_DEF,
    parameter int CW_W = AN_CW_W_DEF,
    parameter int D_W  = AN_D_W_DEF,
    parameter int R_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CW_W-1:0] x,
    output logic [D_W-1:0]  data,
    output logic [R_W-1:0]  rem,
    output logic            err
);

    localparam int K = 2 * CW_W;
    localparam logic [K-1:0]  M     = K'(barrett_m(A, K));
    localparam logic [CW_W:0] A_EXT = (CW_W + 1)'(A);

    logic [CW_W-1:0] x1, x2;
    logic [CW_W-1:0] q0_2, q0_3;
    logic [CW_W:0]   r0_3;
    logic            corr;

    // q0 is at most one below the true quotient, so one conditional subtract suffices.
    assign corr = (r0_3 >= A_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1   <= '0;
            x2   <= '0;
            q0_2 <= '0;
            q0_3 <= '0;
            r0_3 <= '0;
            data <= '0;
            rem  <= '0;
            err  <= 1'b0;
        end else if (en) begin
            x1   <= x;
            x2   <= x1;
            q0_2 <= CW_W'(((CW_W + K)'(x1) * (CW_W + K)'(M)) >> K);
            q0_3 <= q0_2;
            r0_3 <= (CW_W + 1)'(x2) - (CW_W + 1)'(q0_2) * A_EXT;
            data <= D_W'(q0_3 + CW_W'(corr));
            rem  <= R_W'(corr ? r0_3 - A_EXT : r0_3);
            err  <= corr ? (r0_3 != A_EXT) : (r0_3 != '0);
        end
    end

endmodule

// File: rtl/an_barrett_decode_pipe.sv
// Multi-lane AN-code decoder: lane datapaths, shared valid/ready chain and saturating error counter.
module an_barrett_decode_pipe
    import an_code_pkg::*;
#(
    parameter  int A     = AN_A_DEF,
    parameter  int CW_W  = AN_CW_W_DEF,
    parameter  int D_W   = AN_D_W_DEF,
    parameter  int LANES = 36,
    parameter  int CNT_W = 16,
    localparam int R_W   = clog2(A)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*CW_W-1:0]  in_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*D_W-1:0]   out_data,
    output logic [LANES*R_W-1:0]   out_rem,
    output logic [LANES-1:0]       out_err,
    output logic                   out_any_err,
    input  logic                   err_clr,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int STAGES = 3;
    localparam int POP_W  = clog2(LANES + 1);
    localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((A % 2) == 0 || A < 3 || longint'(A) >= (longint'(1) << (CW_W - 1))) begin : g_bad_a
        $error("an_barrett_decode_pipe: A must be odd and in [3, 2^(CW_W-1))");
    end
    if (((longint'(1) << CW_W) - 1) / A >= (longint'(1) << D_W)) begin : g_bad_dw
        $error("an_barrett_decode_pipe: D_W too narrow for max quotient");
    end

    logic              en;
    logic [STAGES:0]   vld_pipe;
    logic [POP_W-1:0]  pop;
    logic [SUM_W-1:0]  sum;

    // Whole pipe moves as one; only the output register can absorb a bubble.
    assign en        = out_ready || !out_valid;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        an_barrett_lane #(
            .A    (A),
            .CW_W (CW_W),
            .D_W  (D_W),
            .R_W  (R_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .x     (in_word[lane_lsb(i, CW_W) +: CW_W]),
            .data  (out_data[lane_lsb(i, D_W) +: D_W]),
            .rem   (out_rem[lane_lsb(i, R_W) +: R_W]),
            .err   (out_err[i])
        );
    end

    assign out_any_err = |out_err;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + POP_W'(out_err[i]);
        end
        sum = SUM_W'(err_cnt) + SUM_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready) begin
            err_cnt <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);
        end
    end

endmodule

// File: tb/tb_an_barrett_decode_pipe.sv
// Directed bench for an_barrett_decode_pipe: vector table, full sweep, backpressure, counter, reset.
module tb_an_barrett_decode_pipe;

    localparam int A     = 37;
    localparam int CW_W  = 18;
    localparam int D_W   = 13;
    localparam int LANES = 36;
    localparam int R_W   = 6;
    localparam int NW    = LANES * CW_W;
    localparam int XMAX  = 1 << CW_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic err_clr = 1'b0;
    logic [NW-1:0] in_word = '0;

    logic                 in_ready, out_valid, out_any_err;
    logic [LANES*D_W-1:0] out_data;
    logic [LANES*R_W-1:0] out_rem;
    logic [LANES-1:0]     out_err;
    logic [15:0]          err_cnt;

    logic                 in_ready4, out_valid4, out_any_err4;
    logic [LANES*D_W-1:0] out_data4;
    logic [LANES*R_W-1:0] out_rem4;
    logic [LANES-1:0]     out_err4;
    logic [3:0]           err_cnt4;

    an_barrett_decode_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rem(out_rem), .out_err(out_err),
        .out_any_err(out_any_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    an_barrett_decode_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_word(in_word), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_rem(out_rem4), .out_err(out_err4),
        .out_any_err(out_any_err4), .err_clr(err_clr), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lq(input int l);
        return int'(out_data[l*D_W +: D_W]);
    endfunction
    function automatic int lr(input int l);
        return int'(out_rem[l*R_W +: R_W]);
    endfunction

    task automatic clr_cnt();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // Send one beat and wait until it sits on the output; returns edges since acceptance.
    task automatic send_wait(input logic [NW-1:0] w, output int k);
        in_word  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
    endtask

    typedef struct {
        int lane;
        int x;
        int q;
        int r;
        bit e;
    } vec_t;

    vec_t vt[5];
    logic [31:0] pat = 32'hB5C3_9A6D;
    logic [NW-1:0] all_err;

    initial begin : main
        int k;
        int sent, recv;
        bit stall, seen;
        logic [LANES*D_W-1:0] snap_d;
        logic [LANES*R_W-1:0] snap_r;
        logic [LANES-1:0]     snap_e;
        int bq[$];
        int nb, b, cyc;

        vt[0] = '{0, 3700, 100, 0, 1'b0};
        vt[1] = '{5, 3701, 100, 1, 1'b1};
        vt[2] = '{7, 262108, 7084, 0, 1'b0};
        vt[3] = '{35, 262143, 7084, 35, 1'b1};
        vt[4] = '{2, 36, 0, 36, 1'b1};
        all_err = '0;
        for (int i = 0; i < LANES; i++) all_err[i*CW_W +: CW_W] = CW_W'(1);

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(|out_data), 0);
        check("rst_out_rem", 32'(|out_rem), 0);
        check("rst_out_any_err", 32'(out_any_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Vector table
        for (int v = 0; v < 5; v++) begin
            logic [NW-1:0] w;
            int other;
            clr_cnt();
            w = '0;
            w[vt[v].lane*CW_W +: CW_W] = CW_W'(vt[v].x);
            out_ready = 1'b1;
            send_wait(w, k);
            other = (vt[v].lane + 1) % LANES;
            check("vec_latency", 32'(k), 3);
            check("vec_data", 32'(lq(vt[v].lane)), 32'(vt[v].q));
            check("vec_rem", 32'(lr(vt[v].lane)), 32'(vt[v].r));
            check("vec_err", 32'(out_err[vt[v].lane]), 32'(vt[v].e));
            check("vec_any_err", 32'(out_any_err), 32'(vt[v].e));
            check("vec_other_lane", 32'(lq(other) + lr(other) + int'(out_err[other])), 0);
            step();
            check("vec_err_cnt", 32'(err_cnt), 32'(vt[v].e));
            check("vec_drained", 32'(out_valid), 0);
        end

        // Full sweep of x over all lanes, out_ready held high
        nb  = (XMAX + LANES - 1) / LANES;
        b   = 0;
        cyc = 0;
        out_ready = 1'b1;
        while ((b < nb || bq.size() > 0) && cyc < nb + 50) begin
            if (out_valid) begin
                if (bq.size() == 0) begin
                    check("sweep_spurious", 32'(out_valid), 0);
                end else begin
                    int bb;
                    bit ok, any;
                    bb  = bq.pop_front();
                    ok  = 1'b1;
                    any = 1'b0;
                    for (int i = 0; i < LANES; i++) begin
                        int x;
                        x = bb * LANES + i;
                        if (x >= XMAX) x = 0;
                        if (lq(i) != x / A || lr(i) != x % A || out_err[i] != ((x % A) != 0)) ok = 1'b0;
                        if ((x % A) != 0) any = 1'b1;
                    end
                    if (out_any_err != any) ok = 1'b0;
                    check("sweep_beat", 32'(ok), 1);
                end
            end
            if (b < nb) begin
                for (int i = 0; i < LANES; i++) begin
                    int x;
                    x = b * LANES + i;
                    in_word[i*CW_W +: CW_W] = (x < XMAX) ? CW_W'(x) : '0;
                end
                in_valid = 1'b1;
                bq.push_back(b);
                b++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("sweep_all_delivered", 32'(bq.size()), 0);

        // Backpressure: 10 beats, lane 0 carries quotient 20+s
        sent  = 0;
        recv  = 0;
        stall = 1'b0;
        snap_d = '0;
        snap_r = '0;
        snap_e = '0;
        for (int c = 0; c < 300 && recv < 10; c++) begin
            out_ready = pat[c % 32];
            in_valid  = (sent < 10);
            in_word   = '0;
            in_word[0 +: CW_W] = CW_W'(A * (sent + 20) + (sent % 3));
            #1;
            if (stall) begin
                check("bp_stable_valid", 32'(out_valid), 1);
                check("bp_stable_data", 32'(out_data == snap_d), 1);
                check("bp_stable_rem_err", 32'((out_rem == snap_r) && (out_err == snap_e)), 1);
            end
            if (out_valid && out_ready) begin
                check("bp_order_data", 32'(lq(0)), 32'(recv + 20));
                check("bp_order_rem", 32'(lr(0)), 32'(recv % 3));
                recv++;
            end
            stall  = out_valid && !out_ready;
            snap_d = out_data;
            snap_r = out_rem;
            snap_e = out_err;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 32'(recv), 10);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("bp_no_duplicate", 32'(seen), 0);

        // Counter saturation and clear
        clr_cnt();
        send_wait(all_err, k);
        step();
        check("sat_cnt16_first", 32'(err_cnt), 36);
        check("sat_cnt4_first", 32'(err_cnt4), 15);
        send_wait(all_err, k);
        step();
        check("sat_cnt16_second", 32'(err_cnt), 72);
        check("sat_cnt4_second", 32'(err_cnt4), 15);
        send_wait(all_err, k);
        check("clr_hs_valid", 32'(out_valid && out_ready), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_wins_cnt16", 32'(err_cnt), 0);
        check("clr_wins_cnt4", 32'(err_cnt4), 0);

        // Reset with beats in flight
        send_wait(all_err, k);
        step();
        check("pre_rst_cnt", 32'(err_cnt), 36);
        out_ready = 1'b0;
        in_word   = all_err;
        in_valid  = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 0);
        check("rst_async_cnt16", 32'(err_cnt), 0);
        check("rst_async_cnt4", 32'(err_cnt4), 0);
        check("rst_async_data", 32'((|out_data) || (|out_err)), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_stale", 32'(seen), 0);
        check("rst_cnt_after", 32'(err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
